// File: rtl/xor_gate.sv
// ---------------------------------------------------------------------------
// xor_gate
//
// Bitwise XOR with a zero-latency combinational result and a clocked
// capture/statistics path that doubles as a lightweight difference monitor.
//
// Parameters
//   WIDTH       operand/result width in bits (>= 1)
//   CNT_W       mismatch counter width in bits (>= 2)
//
// Ports
//   clk         rising-edge clock for the registered outputs
//   rst         synchronous, active-high reset of all registered outputs
//   A, B        operands
//   en          capture enable; pulled high when left unconnected
//   C           combinational A ^ B
//   C_q         registered copy of C
//   parity_q    registered reduction XOR of C
//   any_diff_q  sticky: some captured C was nonzero since reset
//   diff_cnt_q  saturating count of captured cycles with C != 0
// ---------------------------------------------------------------------------
module xor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  tri1              en,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_q,
    output logic             parity_q,
    output logic             any_diff_q,
    output logic [CNT_W-1:0] diff_cnt_q
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

    logic [WIDTH-1:0] C_d;
    logic             parity_d;
    logic             any_diff_d;
    logic [CNT_W-1:0] diff_cnt_d;
    logic             nonzero;

    // Result stage: pure combinational path, independent of clk/rst/en.
    // Per-bit XOR keeps an X/Z on one input bit confined to that result bit.
    always_comb begin
        C       = A ^ B;
        nonzero = |C;
    end

    always_comb begin
        C_d        = C_q;
        parity_d   = parity_q;
        any_diff_d = any_diff_q;
        diff_cnt_d = diff_cnt_q;
        if (en) begin
            C_d      = C;
            parity_d = ^C;
            if (nonzero) begin
                any_diff_d = 1'b1;
                diff_cnt_d = sat_inc(diff_cnt_q);
            end
        end
    end

    // Capture stage: reset has priority over the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            C_q        <= '0;
            parity_q   <= 1'b0;
            any_diff_q <= 1'b0;
            diff_cnt_q <= '0;
        end else begin
            C_q        <= C_d;
            parity_q   <= parity_d;
            any_diff_q <= any_diff_d;
            diff_cnt_q <= diff_cnt_d;
        end
    end

endmodule

// File: tb/tb_xor_gate.sv
module tb_xor_gate;

    logic        clk;
    logic        clk_run;
    logic        rst;
    logic        en;
    logic [7:0]  A8, B8;
    logic        A1, B1;

    logic [7:0]  C8, Cq8;
    logic        par8, any8;
    logic [15:0] cnt8;

    logic [7:0]  C2, Cq2;
    logic        par2, any2;
    logic [1:0]  cnt2;

    logic        C1, Cq1;
    logic        par1, any1;
    logic [15:0] cnt1;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_cq8;
    logic       m_par8, m_any8;
    int         m_cnt8, m_cnt2;
    logic       m_cq1, m_par1, m_any1;
    int         m_cnt1;

    xor_gate #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .A(A8), .B(B8), .en(en),
        .C(C8), .C_q(Cq8), .parity_q(par8), .any_diff_q(any8), .diff_cnt_q(cnt8)
    );

    xor_gate #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .A(A8), .B(B8), .en(en),
        .C(C2), .C_q(Cq2), .parity_q(par2), .any_diff_q(any2), .diff_cnt_q(cnt2)
    );

    xor_gate dut1 (
        .clk(clk), .rst(rst), .A(A1), .B(B1), .en(en),
        .C(C1), .C_q(Cq1), .parity_q(par1), .any_diff_q(any1), .diff_cnt_q(cnt1)
    );

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_add(input int v, input int maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    function automatic logic odd_ones(input logic [7:0] v);
        return (($countones(v) % 2) == 1);
    endfunction

    task automatic check_all();
        chk("C8",     32'(C8),   32'(A8 ^ B8));
        chk("Cq8",    32'(Cq8),  32'(m_cq8));
        chk("par8",   32'(par8), 32'(m_par8));
        chk("any8",   32'(any8), 32'(m_any8));
        chk("cnt8",   32'(cnt8), m_cnt8);
        chk("C2",     32'(C2),   32'(A8 ^ B8));
        chk("Cq2",    32'(Cq2),  32'(m_cq8));
        chk("par2",   32'(par2), 32'(m_par8));
        chk("any2",   32'(any2), 32'(m_any8));
        chk("cnt2",   32'(cnt2), m_cnt2);
        chk("C1",     32'(C1),   32'(A1 ^ B1));
        chk("Cq1",    32'(Cq1),  32'(m_cq1));
        chk("par1",   32'(par1), 32'(m_par1));
        chk("any1",   32'(any1), 32'(m_any1));
        chk("cnt1",   32'(cnt1), m_cnt1);
    endtask

    // One clock edge: model advances from the inputs present at the edge,
    // then every output is compared #1 after it.
    task automatic step();
        logic [7:0] x8;
        logic       x1;
        logic       r, e;
        x8 = A8 ^ B8;
        x1 = A1 ^ B1;
        r  = rst;
        e  = en;
        @(posedge clk);
        #1;
        if (r) begin
            m_cq8 = '0; m_par8 = 1'b0; m_any8 = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
            m_cq1 = 1'b0; m_par1 = 1'b0; m_any1 = 1'b0; m_cnt1 = 0;
        end else if (e) begin
            m_cq8  = x8;
            m_par8 = odd_ones(x8);
            if (x8 != 8'h00) begin
                m_any8 = 1'b1;
                m_cnt8 = sat_add(m_cnt8, 65535);
                m_cnt2 = sat_add(m_cnt2, 3);
            end
            m_cq1  = x1;
            m_par1 = x1;
            if (x1) begin
                m_any1 = 1'b1;
                m_cnt1 = sat_add(m_cnt1, 65535);
            end
        end
        check_all();
    endtask

    initial begin
        logic [1:0] ab;
        clk_run = 1'b0;
        rst = 1'b0;
        en  = 1'b1;
        A8 = 8'h00; B8 = 8'h00;
        A1 = 1'b0;  B1 = 1'b0;
        m_cq8 = '0; m_par8 = 1'b0; m_any8 = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        m_cq1 = 1'b0; m_par1 = 1'b0; m_any1 = 1'b0; m_cnt1 = 0;

        // Combinational path with no clock running.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            A1 = ab[1];
            B1 = ab[0];
            #2;
            chk("noclk_C_early", 32'(C1), 32'(ab[1] != ab[0]));
            #7;
            chk("noclk_C_late", 32'(C1), 32'(ab[1] != ab[0]));
            #1;
        end

        // Reset state.
        clk_run = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;

        // A5 ^ 0F.
        A8 = 8'hA5; B8 = 8'h0F; A1 = 1'b1; B1 = 1'b0;
        #1;
        chk("C_A5_0F_immediate", 32'(C8), 32'h0000_00AA);
        step();
        chk("Cq_AA", 32'(Cq8), 32'h0000_00AA);
        chk("par_AA", 32'(par8), 32'h0);
        chk("any_AA", 32'(any8), 32'h1);
        chk("cnt_AA", 32'(cnt8), 32'h1);

        // 5 equal edges, then 3 differing edges.
        rst = 1'b1;
        step();
        rst = 1'b0;
        A8 = 8'h3C; B8 = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("any_equal_run", 32'(any8), 32'h0);
        end
        A8 = 8'h3D;
        step();
        chk("any_6th_edge", 32'(any8), 32'h1);
        step();
        step();
        chk("cnt_after_3_diff", 32'(cnt8), 32'h3);
        chk("par_after_3_diff", 32'(par8), 32'h1);

        // Hold with en=0 while inputs toggle.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A8 = 8'(i * 37 + 5); B8 = ~A8; A1 = ~A1;
            step();
            chk("hold_cnt", 32'(cnt8), 32'h3);
            chk("hold_Cq", 32'(Cq8), 32'h0000_0001);
        end
        en = 1'b1;

        // CNT_W=2 saturation.
        rst = 1'b1;
        step();
        rst = 1'b0;
        A8 = 8'h01; B8 = 8'h00;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("sat_cnt2", 32'(cnt2), (i < 3) ? i : 3);
            chk("sat_any2", 32'(any2), 32'h1);
        end

        // Mid-run reset with counter at 3 and en=1.
        rst = 1'b1;
        step();
        chk("midrst_cnt2", 32'(cnt2), 32'h0);
        chk("midrst_any2", 32'(any2), 32'h0);
        chk("midrst_Cq2", 32'(Cq2), 32'h0);
        chk("midrst_C2", 32'(C2), 32'h1);
        rst = 1'b0;

        // Randomized run against the model.
        for (int i = 0; i < 300; i++) begin
            A8 = 8'($urandom);
            B8 = ($urandom_range(0, 2) == 0) ? A8 : 8'($urandom);
            A1 = 1'($urandom);
            B1 = 1'($urandom);
            en = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
